// File: rtl/gpio_pkg.sv
// Shared register map for the GPIO MMIO responder: window size and word offsets.
package gpio_pkg;

    localparam int unsigned WINDOW_BYTES = 32;
    localparam int unsigned WINDOW_AW    = $clog2(WINDOW_BYTES);

    typedef enum logic [2:0] {
        OFF_OUT       = 3'd0,
        OFF_IN        = 3'd1,
        OFF_EDGE_STAT = 3'd2,
        OFF_IRQ_EN    = 3'd3,
        OFF_SET       = 3'd4,
        OFF_CLR       = 3'd5,
        OFF_RSVD6     = 3'd6,
        OFF_RSVD7     = 3'd7
    } reg_off_e;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin debounce filter: the output follows the input only after the input
// has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module gpio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             state_r;
    logic             state_next_s;

    // Count consecutive disagreeing clocks; any reversion restarts the count.
    always_comb begin
        cnt_next_s   = CNT_ZERO;
        state_next_s = state_r;
        if (raw != state_r) begin
            if (cnt_r == CNT_LAST) begin
                state_next_s = raw;
                cnt_next_s   = CNT_ZERO;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = CNT_ZERO;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r   <= CNT_ZERO;
            state_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            state_r <= state_next_s;
        end
    end

    assign filtered = state_r;

endmodule

// File: rtl/gpio_mmio_responder.sv
// Memory-mapped GPIO block: OUT/IN/EDGE_STAT/IRQ_EN/SET/CLR in a 32-byte window.
// Optional per-pin debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_mmio_responder
    import gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
    parameter int unsigned GPIO_WIDTH      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Address_i,
    input  logic [31:0]           WriteData_i,
    input  logic                  MemWrite_i,
    output logic [31:0]           ReadData_o,
    output logic                  sel_o,
    input  logic [GPIO_WIDTH-1:0] gpio_in_i,
    output logic [GPIO_WIDTH-1:0] gpio_out_o,
    output logic                  irq_o
);

    localparam logic [GPIO_WIDTH-1:0] ZERO_W  = {GPIO_WIDTH{1'b0}};
    localparam logic [31:0]           DEB_VEC = 32'(DEBOUNCE_CYCLES);

    logic                  sel_s;
    logic                  wr_s;
    reg_off_e              off_s;
    logic [GPIO_WIDTH-1:0] wdata_s;
    logic [GPIO_WIDTH-1:0] sync1_r;
    logic [GPIO_WIDTH-1:0] sync2_r;
    logic [GPIO_WIDTH-1:0] in_s;
    logic [GPIO_WIDTH-1:0] prev_r;
    logic [GPIO_WIDTH-1:0] edge_s;
    logic [GPIO_WIDTH-1:0] out_r;
    logic [GPIO_WIDTH-1:0] out_next_s;
    logic [GPIO_WIDTH-1:0] stat_r;
    logic [GPIO_WIDTH-1:0] stat_next_s;
    logic [GPIO_WIDTH-1:0] en_r;
    logic [GPIO_WIDTH-1:0] en_next_s;
    logic                  irq_r;
    logic [31:0]           rdata_s;
    logic                  unused_s;

    assign sel_s   = (Address_i[31:WINDOW_AW] == BASE_ADDR[31:WINDOW_AW]);
    assign wr_s    = MemWrite_i & sel_s;
    assign off_s   = reg_off_e'(Address_i[4:2]);
    assign wdata_s = WriteData_i[GPIO_WIDTH-1:0];
    assign edge_s  = in_s & ~prev_r;

    // Byte lanes, high data bits and the debounce length are not needed in every build.
    assign unused_s = ^{Address_i[1:0], WriteData_i, DEB_VEC[0]};

`ifdef GPIO_DEBOUNCE_EN
    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_deb
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .raw      (sync2_r[g]),
            .filtered (in_s[g])
        );
    end
`else
    assign in_s = sync2_r;
`endif

    // Bus write decode; a fresh edge always wins over a W1C on the same bit.
    always_comb begin
        out_next_s  = out_r;
        en_next_s   = en_r;
        stat_next_s = stat_r | edge_s;
        if (wr_s) begin
            case (off_s)
                OFF_OUT:       out_next_s  = wdata_s;
                OFF_SET:       out_next_s  = out_r | wdata_s;
                OFF_CLR:       out_next_s  = out_r & ~wdata_s;
                OFF_IRQ_EN:    en_next_s   = wdata_s;
                OFF_EDGE_STAT: stat_next_s = (stat_r & ~wdata_s) | edge_s;
                default:       out_next_s  = out_r;
            endcase
        end else begin
            out_next_s = out_r;
        end
    end

    // Register state, input synchronizer, edge history and interrupt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_r   <= ZERO_W;
            stat_r  <= ZERO_W;
            en_r    <= ZERO_W;
            sync1_r <= ZERO_W;
            sync2_r <= ZERO_W;
            prev_r  <= ZERO_W;
            irq_r   <= 1'b0;
        end else begin
            out_r   <= out_next_s;
            stat_r  <= stat_next_s;
            en_r    <= en_next_s;
            sync1_r <= gpio_in_i;
            sync2_r <= sync1_r;
            prev_r  <= in_s;
            irq_r   <= |(stat_r & en_r);
        end
    end

    // Load data mux; write-only and reserved words read as zero.
    always_comb begin
        rdata_s = 32'd0;
        if (sel_s) begin
            case (off_s)
                OFF_OUT:       rdata_s[GPIO_WIDTH-1:0] = out_r;
                OFF_IN:        rdata_s[GPIO_WIDTH-1:0] = in_s;
                OFF_EDGE_STAT: rdata_s[GPIO_WIDTH-1:0] = stat_r;
                OFF_IRQ_EN:    rdata_s[GPIO_WIDTH-1:0] = en_r;
                default:       rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign ReadData_o = rdata_s;
    assign sel_o      = sel_s;
    assign gpio_out_o = out_r;
    assign irq_o      = irq_r;

endmodule

// File: tb/tb_gpio_mmio_responder.sv
// Self-checking bench for gpio_mmio_responder: directed vector table, randomized
// traffic against a reference model, and a debounce sequence when GPIO_DEBOUNCE_EN is set.
module tb_gpio_mmio_responder;

    localparam logic [31:0] B = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address_i;
    logic [31:0] WriteData_i;
    logic        MemWrite_i;
    logic [31:0] ReadData_o;
    logic        sel_o;
    logic [7:0]  gpio_in_i;
    logic [7:0]  gpio_out_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state: register contents plus the pin values seen at recent edges.
    logic [7:0] m_out;
    logic [7:0] m_en;
    logic [7:0] m_stat;
    logic       m_irq;
    logic [7:0] m_pq[$];

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [7:0]  pins;
        logic [7:0]  e_out;
        logic        e_irq;
        logic        e_sel;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    gpio_mmio_responder #(
        .BASE_ADDR       (32'h1001_0000),
        .GPIO_WIDTH      (8),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Address_i   (Address_i),
        .WriteData_i (WriteData_i),
        .MemWrite_i  (MemWrite_i),
        .ReadData_o  (ReadData_o),
        .sel_o       (sel_o),
        .gpio_in_i   (gpio_in_i),
        .gpio_out_o  (gpio_out_o),
        .irq_o       (irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [7:0] pins);
        reset       = rst;
        MemWrite_i  = we;
        Address_i   = addr;
        WriteData_i = wd;
        gpio_in_i   = pins;
    endtask

    function automatic logic model_sel(input logic [31:0] a);
        return a[31:5] == B[31:5];
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (model_sel(a)) begin
            case (a[4:2])
                3'd0:    r = {24'd0, m_out};
                3'd1:    r = {24'd0, m_pq[1]};
                3'd2:    r = {24'd0, m_stat};
                3'd3:    r = {24'd0, m_en};
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    // Apply the effect of one rising edge with the inputs currently driven.
    task automatic model_step();
        logic [7:0] edge_v;
        logic [7:0] w1c;
        logic       irq_new;
        logic       hit;
        logic [2:0] off;
        if (!reset) begin
            m_out  = 8'h00;
            m_en   = 8'h00;
            m_stat = 8'h00;
            m_irq  = 1'b0;
            m_pq   = '{8'h00, 8'h00, 8'h00};
        end else begin
            irq_new = |(m_stat & m_en);
            edge_v  = m_pq[1] & ~m_pq[2];
            hit     = MemWrite_i && model_sel(Address_i);
            off     = Address_i[4:2];
            w1c     = (hit && off == 3'd2) ? WriteData_i[7:0] : 8'h00;
            m_stat  = (m_stat & ~w1c) | edge_v;
            if (hit) begin
                case (off)
                    3'd0:    m_out = WriteData_i[7:0];
                    3'd3:    m_en  = WriteData_i[7:0];
                    3'd4:    m_out = m_out | WriteData_i[7:0];
                    3'd5:    m_out = m_out & ~WriteData_i[7:0];
                    default: ;
                endcase
            end
            m_pq.push_front(gpio_in_i);
            void'(m_pq.pop_back());
            m_irq = irq_new;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic add(input logic rst, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [7:0] pins, input logic [7:0] e_out, input logic e_irq,
                       input logic e_sel, input logic [31:0] e_rd);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.wd = wd; v.pins = pins;
        v.e_out = e_out; v.e_irq = e_irq; v.e_sel = e_sel; v.e_rd = e_rd;
        vq.push_back(v);
    endtask

    initial begin
        drive(1'b0, 1'b0, B, 32'd0, 8'h00);
        m_pq = '{8'h00, 8'h00, 8'h00};
        m_out = 8'h00; m_en = 8'h00; m_stat = 8'h00; m_irq = 1'b0;

`ifndef GPIO_DEBOUNCE_EN
        //   rst   we    addr           wd           pins   out    irq   sel   rd
        add(1'b0, 1'b1, B,           32'hFF,     8'h00, 8'h00, 1'b0, 1'b1, 32'h00); // write under reset
        add(1'b1, 1'b1, B,           32'hA5,     8'h00, 8'hA5, 1'b0, 1'b1, 32'hA5);
        add(1'b1, 1'b1, B + 32'h10,  32'h0A,     8'h00, 8'hAF, 1'b0, 1'b1, 32'h00);
        add(1'b1, 1'b1, B + 32'h14,  32'h81,     8'h00, 8'h2E, 1'b0, 1'b1, 32'h00);
        add(1'b1, 1'b0, B,           32'h00,     8'h00, 8'h2E, 1'b0, 1'b1, 32'h2E);
        add(1'b1, 1'b1, B + 32'h0C,  32'h01,     8'h00, 8'h2E, 1'b0, 1'b1, 32'h01);
        add(1'b1, 1'b0, B + 32'h04,  32'h00,     8'h01, 8'h2E, 1'b0, 1'b1, 32'h00); // pin 0 rises
        add(1'b1, 1'b0, B + 32'h04,  32'h00,     8'h01, 8'h2E, 1'b0, 1'b1, 32'h01);
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h2E, 1'b0, 1'b1, 32'h01);
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h2E, 1'b1, 1'b1, 32'h01);
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h00, 8'h2E, 1'b1, 1'b1, 32'h01);
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h2E, 1'b1, 1'b1, 32'h01);
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h2E, 1'b1, 1'b1, 32'h01);
        add(1'b1, 1'b1, B + 32'h08,  32'h01,     8'h01, 8'h2E, 1'b1, 1'b1, 32'h01); // W1C meets edge
        add(1'b1, 1'b1, B + 32'h08,  32'h01,     8'h01, 8'h2E, 1'b1, 1'b1, 32'h00);
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h2E, 1'b0, 1'b1, 32'h00);
        add(1'b1, 1'b1, B + 32'h20,  32'hFF,     8'h01, 8'h2E, 1'b0, 1'b0, 32'h00); // outside window
        add(1'b1, 1'b1, B + 32'h18,  32'hFF,     8'h01, 8'h2E, 1'b0, 1'b1, 32'h00); // reserved
        add(1'b1, 1'b1, B + 32'h04,  32'hFF,     8'h01, 8'h2E, 1'b0, 1'b1, 32'h01);
        add(1'b1, 1'b0, B,           32'h00,     8'h01, 8'h2E, 1'b0, 1'b1, 32'h2E);
        add(1'b1, 1'b0, B + 32'h0C,  32'h00,     8'h01, 8'h2E, 1'b0, 1'b1, 32'h01);
        add(1'b0, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h00, 1'b0, 1'b1, 32'h00); // reset, pins high
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h00, 1'b0, 1'b1, 32'h00);
        add(1'b1, 1'b0, B + 32'h04,  32'h00,     8'h01, 8'h00, 1'b0, 1'b1, 32'h01);
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h00, 1'b0, 1'b1, 32'h01);
        add(1'b1, 1'b1, B + 32'h08,  32'h01,     8'h01, 8'h00, 1'b0, 1'b1, 32'h00);
        add(1'b1, 1'b0, B + 32'h08,  32'h00,     8'h01, 8'h00, 1'b0, 1'b1, 32'h00);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].we, vq[i].addr, vq[i].wd, vq[i].pins);
            tick();
            chk($sformatf("row%0d_out", i), {24'd0, gpio_out_o}, {24'd0, vq[i].e_out});
            chk($sformatf("row%0d_irq", i), {31'd0, irq_o}, {31'd0, vq[i].e_irq});
            chk($sformatf("row%0d_sel", i), {31'd0, sel_o}, {31'd0, vq[i].e_sel});
            chk($sformatf("row%0d_rd", i), ReadData_o, vq[i].e_rd);
        end

        // Randomized traffic against the reference model.
        drive(1'b0, 1'b0, B, 32'd0, 8'h00);
        tick();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [7:0]  p;
            a = ($urandom_range(0, 7) == 0) ? $urandom : (B + 32'($urandom_range(0, 31)));
            p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : gpio_in_i;
            drive(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), a, $urandom, p);
            tick();
            chk("rnd_out", {24'd0, gpio_out_o}, {24'd0, m_out});
            chk("rnd_irq", {31'd0, irq_o}, {31'd0, m_irq});
            chk("rnd_sel", {31'd0, sel_o}, {31'd0, model_sel(Address_i)});
            chk("rnd_rd", ReadData_o, model_rd(Address_i));
        end
`else
        // Short pulse on pin 1 is filtered out entirely.
        drive(1'b0, 1'b0, B + 32'h04, 32'd0, 8'h00);
        tick();
        drive(1'b1, 1'b0, B + 32'h04, 32'd0, 8'h00);
        for (int k = 0; k < 3; k++) tick();
        for (int k = 1; k <= 35; k++) begin
            gpio_in_i = (k <= 10) ? 8'h02 : 8'h00;
            tick();
            chk($sformatf("deb_short_in_k%0d", k), ReadData_o, 32'h00);
        end
        Address_i = B + 32'h08;
        #1;
        chk("deb_short_edge", ReadData_o, 32'h00);
        chk("deb_short_irq", {31'd0, irq_o}, 32'd0);
        // Long pulse on pin 1 reaches IN after sync plus filter delay.
        Address_i = B + 32'h04;
        for (int k = 1; k <= 20; k++) begin
            gpio_in_i = 8'h02;
            tick();
            chk($sformatf("deb_long_in_k%0d", k), ReadData_o, (k >= 18) ? 32'h02 : 32'h00);
        end
        Address_i = B + 32'h08;
        gpio_in_i = 8'h00;
        tick();
        tick();
        chk("deb_long_edge", ReadData_o, 32'h02);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_mmio_responder.md
GPIO_MMIO_RESPONDER -- requirements
Module: gpio_mmio_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1001_0000, base of the 32-byte register window (aligned to 32 bytes).
REQ-002 SHALL have parameter GPIO_WIDTH, default 8, number of input and output pins (1..32).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, filter length in clocks (used only with the debounce feature).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port Address_i, input, 32: byte address driven by the core.
REQ-007 SHALL have port WriteData_i, input, 32: store data from the core.
REQ-008 SHALL have port MemWrite_i, input, 1: store strobe, one beat per cycle.
REQ-009 SHALL have port ReadData_o, output, 32: load data, combinational from Address_i and register state.
REQ-010 SHALL have port sel_o, output, 1: high when Address_i[31:5] equals BASE_ADDR[31:5]; the top-level read mux uses it.
REQ-011 SHALL have port gpio_in_i, input, GPIO_WIDTH: asynchronous external pins.
REQ-012 SHALL have port gpio_out_o, output, GPIO_WIDTH: registered output pins.
REQ-013 SHALL have port irq_o, output, 1: registered, level interrupt.

Function
REQ-014 SHALL decode word offset Address_i[4:2]; byte offsets [1:0] are ignored.
- 0 OUT: RW.
- 1 IN: RO.
- 2 EDGE_STAT: W1C.
- 3 IRQ_EN: RW.
- 4 SET: WO, reads 0.
- 5 CLR: WO, reads 0.
- 6, 7: reserved, read 0.
REQ-015 SHALL commit a write on the rising edge where MemWrite_i=1 and sel_o=1; otherwise no state changes from the bus.
REQ-016 SHALL handle a write to SET as OUT <= OUT | WriteData_i[GPIO_WIDTH-1:0].
REQ-017 SHALL handle a write to CLR as OUT <= OUT & ~WriteData_i[GPIO_WIDTH-1:0].
REQ-018 SHALL ignore writes to IN, reserved offsets and addresses with sel_o=0.
REQ-019 SHALL drive ReadData_o=0 when sel_o=0; register bits above GPIO_WIDTH read 0.
REQ-020 SHALL pass gpio_in_i through a two-flop synchronizer; the result is visible in IN two clocks after a pin change (macro absent).
REQ-021 SHALL keep a delayed copy of the IN value and set EDGE_STAT[i] on each cycle where IN[i]=1 and the delayed copy[i]=0 (rising edge only).
REQ-022 SHALL give a set priority over clearing when an edge and a W1C write hit the same bit in the same cycle: the bit stays 1.
REQ-023 SHALL register irq_o <= |(EDGE_STAT & IRQ_EN) every cycle, giving one cycle of latency after the status or enable change.
REQ-024 SHALL make end-to-end latency, pin rise to irq_o high, exactly 4 clocks without the debounce feature.

Reset
REQ-025 SHALL clear the following while reset=0 at a clock edge: OUT, EDGE_STAT, IRQ_EN, synchronizer flops, delayed copy, debounce counters, irq_o.
- After reset, gpio_out_o=0 and irq_o=0.
REQ-026 SHALL give reset priority over a simultaneous bus write.
REQ-027 SHALL not produce a spurious edge when reset releases while pins are high (delayed copy and IN both start at 0; a real edge is then reported once).

Configuration
REQ-028 SHALL add a per-bit debounce filter between the synchronizer and IN when GPIO_DEBOUNCE_EN is defined.
- IN[i] updates only after the synchronized value has differed from IN[i] for DEBOUNCE_CYCLES consecutive clocks.
- The counter restarts on any reversion.
REQ-029 SHALL feed the synchronizer output directly to IN when GPIO_DEBOUNCE_EN is undefined, and SHALL instantiate no counters.

Structure
REQ-030 SHALL place the word offsets OFF_OUT..OFF_CLR and the window size constant in shared package gpio_pkg.
REQ-031 SHALL implement the per-bit filter as one sub-module, gpio_debounce, instantiated GPIO_WIDTH times under the macro.

Verification
REQ-032 SHALL cover: reset=0 with MemWrite_i=1, OUT write 0xFF -> gpio_out_o stays 0x00.
REQ-033 SHALL cover: write OUT=0xA5, then SET 0x0A, then CLR 0x81 -> gpio_out_o 0xA5, 0xAF, 0x2E; read offset 0 returns 0x0000002E.
REQ-034 SHALL cover: IRQ_EN=0x01, gpio_in_i[0] rises -> IN reads 0x01 after 2 clocks, EDGE_STAT=0x01 after 3, irq_o=1 after 4.
REQ-035 SHALL cover: W1C 0x01 to EDGE_STAT in the same cycle as a new edge on bit 0 -> bit stays 1; a later W1C with no edge clears it and irq_o drops the next cycle.
REQ-036 SHALL cover: read at BASE_ADDR+0x20 and BASE_ADDR+0x18 -> sel_o=0/ReadData_o=0 and sel_o=1/ReadData_o=0; writes there change nothing.
REQ-037 SHALL cover, with GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-clock pulse on pin 1 -> IN unchanged, no edge; a 20-clock pulse -> IN[1]=1 after 18 clocks.
